// File: rtl/rf_pkg.sv
// rf_pkg: shared baseband widths, FSK states and quarter-wave sine table.
// Shared by fsk_mod and fm_demod so that both ends agree on the I/Q format.
package rf_pkg;

  localparam int SAMPLE_W = 8;
  localparam int AMP      = (1 << (SAMPLE_W - 1)) - 1;
  localparam int LUT_AW   = 6;
  localparam int LUT_N    = 1 << LUT_AW;
  localparam int PHASE_W  = 16;

  typedef logic signed [SAMPLE_W-1:0] sample_t;

  typedef enum logic {
    IDLE,
    SEND
  } fsk_state_t;

  // round(AMP * sin(k*pi/(2*LUT_N))), k = 0..LUT_N, for AMP=127, LUT_AW=6
  localparam logic [SAMPLE_W-2:0] SIN_TBL [0:LUT_N] = '{
    7'd0,   7'd3,   7'd6,   7'd9,   7'd12,  7'd16,  7'd19,  7'd22,
    7'd25,  7'd28,  7'd31,  7'd34,  7'd37,  7'd40,  7'd43,  7'd46,
    7'd49,  7'd51,  7'd54,  7'd57,  7'd60,  7'd63,  7'd65,  7'd68,
    7'd71,  7'd73,  7'd76,  7'd78,  7'd81,  7'd83,  7'd85,  7'd88,
    7'd90,  7'd92,  7'd94,  7'd96,  7'd98,  7'd100, 7'd102, 7'd104,
    7'd106, 7'd107, 7'd109, 7'd111, 7'd112, 7'd113, 7'd115, 7'd116,
    7'd117, 7'd118, 7'd120, 7'd121, 7'd122, 7'd122, 7'd123, 7'd124,
    7'd125, 7'd125, 7'd126, 7'd126, 7'd126, 7'd127, 7'd127, 7'd127,
    7'd127
  };

endpackage

// File: rtl/fsk_mod_if.sv
// fsk_mod_if: bit handshake in (data_i/dvalid_i/ready_o) and I/Q samples out.
// master = bit source and sample sink, slave = the modulator.
interface fsk_mod_if;
  import rf_pkg::*;

  logic    data_i;
  logic    dvalid_i;
  logic    ready_o;
  logic    busy_o;
  sample_t I_o;
  sample_t Q_o;
  logic    dvalid_o;

  modport master (
    output data_i, dvalid_i,
    input  ready_o, busy_o, I_o, Q_o, dvalid_o
  );

  modport slave (
    input  data_i, dvalid_i,
    output ready_o, busy_o, I_o, Q_o, dvalid_o
  );

endinterface

// File: rtl/sin_lut.sv
// sin_lut: two-stage registered sine lookup with quadrant mirroring.
// Ports: clk, rst_n, load (capture addr), addr (quad+index), emit (update y), y.
module sin_lut
  import rf_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic [LUT_AW+1:0] addr,
  input  logic              emit,
  output sample_t           y
);

  logic [1:0]        quad;
  logic [LUT_AW-1:0] idx;
  logic [LUT_AW:0]   k;
  sample_t           mag;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      quad <= '0;
      idx  <= '0;
    end else if (load) begin
      quad <= addr[LUT_AW+1 -: 2];
      idx  <= addr[LUT_AW-1:0];
    end
  end

  // Odd quadrants read the table backwards; upper half-wave is negated.
  always_comb begin
    k = {1'b0, idx};
    if (quad[0]) k = (LUT_AW+1)'(LUT_N) - {1'b0, idx};
    mag = sample_t'({1'b0, SIN_TBL[k]});
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) y <= '0;
    else if (emit) y <= quad[1] ? -mag : mag;
  end

endmodule

// File: rtl/fsk_mod.sv
// fsk_mod: continuous-phase binary FSK modulator, bits in, I/Q samples out.
// Ports: clk, nrst_i (async, active low), bus (fsk_mod_if.slave).
module fsk_mod
  import rf_pkg::*;
#(
  parameter int CLK_DIV = 16,
  parameter int SPB     = 8,
  parameter int DEV_INC = 2048
)(
  input logic      clk,
  input logic      nrst_i,
  fsk_mod_if.slave bus
);

  localparam int DW = $clog2(CLK_DIV);
  localparam int SW = $clog2(SPB + 1);
  localparam logic [PHASE_W-1:0] STEP = PHASE_W'(DEV_INC);

  fsk_state_t         state, state_n;
  logic [DW-1:0]      div_cnt;
  logic [SW-1:0]      smp_cnt, smp_n;
  logic [PHASE_W-1:0] phase, phase_n;
  logic               cur_bit, cur_n;
  logic               nxt_bit, nxt_bit_n;
  logic               nxt_valid, nxt_valid_n;
  logic               tick, last, accept, fire, v1;
  logic [LUT_AW+1:0]  addr_s, addr_c;

  assign tick   = div_cnt == DW'(CLK_DIV - 1);
  assign last   = smp_cnt == SW'(SPB - 1);
  assign accept = bus.dvalid_i & ~nxt_valid;

  assign bus.ready_o = ~nxt_valid;
  assign bus.busy_o  = state == SEND;

  always_ff @(posedge clk or negedge nrst_i) begin
    if (!nrst_i) div_cnt <= '0;
    else if (tick) div_cnt <= '0;
    else div_cnt <= div_cnt + 1'b1;
  end

  always_comb begin
    state_n     = state;
    smp_n       = smp_cnt;
    phase_n     = phase;
    cur_n       = cur_bit;
    nxt_bit_n   = nxt_bit;
    nxt_valid_n = nxt_valid;
    fire        = 1'b0;
    unique case (state)
      IDLE: begin
        if (accept) begin
          cur_n       = bus.data_i;
          nxt_valid_n = 1'b0;
          smp_n       = '0;
          state_n     = SEND;
        end
      end
      SEND: begin
        if (accept) begin
          nxt_bit_n   = bus.data_i;
          nxt_valid_n = 1'b1;
        end
        if (tick) begin
          fire    = 1'b1;
          phase_n = cur_bit ? phase + STEP : phase - STEP;
          smp_n   = smp_cnt + 1'b1;
          if (last) begin
            smp_n = '0;
            // Holding register first; else a bit offered right now
            // bypasses straight in so the stream has no gap.
            if (nxt_valid) begin
              cur_n       = nxt_bit;
              nxt_valid_n = 1'b0;
            end else if (accept) begin
              cur_n       = bus.data_i;
              nxt_valid_n = 1'b0;
            end else begin
              state_n = IDLE;
            end
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge nrst_i) begin
    if (!nrst_i) begin
      state     <= IDLE;
      smp_cnt   <= '0;
      phase     <= '0;
      cur_bit   <= 1'b0;
      nxt_bit   <= 1'b0;
      nxt_valid <= 1'b0;
    end else begin
      state     <= state_n;
      smp_cnt   <= smp_n;
      phase     <= phase_n;
      cur_bit   <= cur_n;
      nxt_bit   <= nxt_bit_n;
      nxt_valid <= nxt_valid_n;
    end
  end

  always_ff @(posedge clk or negedge nrst_i) begin
    if (!nrst_i) begin
      v1           <= 1'b0;
      bus.dvalid_o <= 1'b0;
    end else begin
      v1           <= fire;
      bus.dvalid_o <= v1;
    end
  end

  // cos(p) = sin(p + quarter turn): bump the quadrant field by one.
  assign addr_s = phase[PHASE_W-1 -: LUT_AW+2];
  assign addr_c = addr_s + (LUT_AW+2)'(LUT_N);

  sin_lut u_q (
    .clk   (clk),
    .rst_n (nrst_i),
    .load  (fire),
    .addr  (addr_s),
    .emit  (v1),
    .y     (bus.Q_o)
  );

  sin_lut u_i (
    .clk   (clk),
    .rst_n (nrst_i),
    .load  (fire),
    .addr  (addr_c),
    .emit  (v1),
    .y     (bus.I_o)
  );

endmodule
